regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (w_en / rd_id / write data) between two writeback sources.
- Source A is the ALU/CSR path; source B is the load/multi-cycle path.
- Each source has a small FIFO. A round-robin arbiter drains the FIFOs into the write port, one register write per cycle.
- Sits between the writeback stage and the register file, replacing the direct RegWr/Rw/busW connection.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  source A presents a write.
- a_ready  out  1  source A FIFO can accept.
- a_rd  in  ADDR_W  source A destination register.
- a_data  in  DATA_W  source A write data.
- b_valid  in  1  source B presents a write.
- b_ready  out  1  source B FIFO can accept.
- b_rd  in  ADDR_W  source B destination register.
- b_data  in  DATA_W  source B write data.
- w_en  out  1  write strobe to the register file.
- rd_id_o  out  ADDR_W  register index to the register file.
- rd_write_data_o  out  DATA_W  data to the register file.
- busy  out  1  at least one FIFO is non-empty.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Both FIFOs are emptied: read and write pointers and counts go to 0.
  - The round-robin pointer is set so that A has priority next.
  - Pending entries are discarded with no write issued, including when reset arrives mid-drain.
  - After reset: w_en=0, busy=0, a_ready=1, b_ready=1. rd_id_o and rd_write_data_o are 0 whenever w_en=0.
- Handshake:
  - A transfer occurs when x_valid && x_ready at a rising edge.
  - x_ready = !full(x). It is a function of registered state only and has no combinational path from x_valid or from the arbiter.
  - A full FIFO refuses an enqueue even in a cycle in which it is being popped.
  - A producer holds x_valid/x_rd/x_data stable until accepted.
- x0 filter: a transfer with x_rd == 0 completes the handshake but is not stored and never produces a write.
- Enqueue: the accepted entry {rd, data} is written at the tail and the count is incremented.
- Arbitration is combinational from the FIFO heads:
  - Only A non-empty: grant A.
  - Only B non-empty: grant B.
  - Both non-empty: grant the source not granted last; after reset A is chosen first.
  - The round-robin pointer updates only on a grant.
- Write port:
  - w_en = granted FIFO non-empty; rd_id_o and rd_write_data_o come from the granted head.
  - The head is popped at the same rising edge at which the register file samples the write.
- Latency:
  - An entry accepted at edge N is written at edge N+1 if its source wins.
  - Under continuous contention it waits at most FIFO_DEPTH*2-1 cycles.
- Ordering:
  - FIFO order is preserved within a source.
  - Across sources, order follows the grant sequence. Same-rd WAW across sources is resolved by issuing order, and keeping that safe is the upstream scoreboard's responsibility.
- Simultaneous enqueue and pop on the same FIFO (not full): count is unchanged and both pointers advance; pointer wrap is modulo FIFO_DEPTH.
- busy = |count_a || |count_b.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- When defined, the block adds outputs:
  - stall_a_cnt (16-bit): increments on each cycle with a_valid && !a_ready.
  - stall_b_cnt (16-bit): same, for source B.
  - conflict_cnt (16-bit): increments on each cycle in which both FIFOs are non-empty.
- All three counters saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle: w_en=0, busy=0, a_ready=b_ready=1. Then pulse rst while both FIFOs hold entries: the next cycle shows w_en=0 and no further writes.
- Single A write {rd=5, data=32'hDEADBEEF} accepted at edge N: w_en=1, rd_id_o=5, rd_write_data_o=32'hDEADBEEF in cycle N+1; busy drops after edge N+1.
- A and B both valid every cycle from reset (A rd=1,2,3..., B rd=17,18,19...): write sequence is 1,17,2,18,3,19...; strictly alternating, with no lost entries.
- Hold B valid with the output path saturated by A: b_ready goes 0 after FIFO_DEPTH accepts, and no enqueue happens while full even during a pop. With WB_ARB_PERF_EN, stall_b_cnt equals the number of refused cycles.
- A write with rd=0, data=32'h1234: handshake completes (a_ready=1), and w_en stays 0 for all following cycles.
- Back-to-back A-only writes at full rate for 8 cycles: one write per cycle, FIFO order preserved across pointer wrap, a_ready never drops.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-source writeback arbiter for the register-file write port.
//               Per-source FIFOs drained round-robin, one write per cycle.
//               Optional perf counters enabled by defining WB_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module wb_arb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              ready_o,
    output logic              nonempty_o,
    output logic [ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0] head_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic do_push;
    logic do_pop;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign full        = (count_q == C_FULL_CNT);
    assign ready_o     = !full;
    assign nonempty_o  = (count_q != '0);
    assign do_push     = push_i && !full;
    assign do_pop      = pop_i && nonempty_o;
    assign head_rd_o   = rd_mem_q[rptr_q];
    assign head_data_o = data_mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem_q[wptr_q]   <= rd_i;
            data_mem_q[wptr_q] <= data_i;
        end
    end

endmodule

module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              w_en,
    output logic [ADDR_W-1:0] rd_id_o,
    output logic [DATA_W-1:0] rd_write_data_o,
`ifdef WB_ARB_PERF_EN
    output logic [15:0]       stall_a_cnt,
    output logic [15:0]       stall_b_cnt,
    output logic [15:0]       conflict_cnt,
`endif
    output logic              busy
);

    logic              push_a, push_b;
    logic              ne_a, ne_b;
    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] head_rd_a, head_rd_b;
    logic [DATA_W-1:0] head_data_a, head_data_b;
    logic              prio_a_q, prio_a_d;

    // Writes to x0 are accepted but dropped before they reach the FIFO.
    assign push_a = a_valid && (a_rd != '0);
    assign push_b = b_valid && (b_rd != '0);

    wb_arb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo_a (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_a),
        .rd_i        (a_rd),
        .data_i      (a_data),
        .pop_i       (grant_a),
        .ready_o     (a_ready),
        .nonempty_o  (ne_a),
        .head_rd_o   (head_rd_a),
        .head_data_o (head_data_a)
    );

    wb_arb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo_b (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_b),
        .rd_i        (b_rd),
        .data_i      (b_data),
        .pop_i       (grant_b),
        .ready_o     (b_ready),
        .nonempty_o  (ne_b),
        .head_rd_o   (head_rd_b),
        .head_data_o (head_data_b)
    );

    // prio_a_q set means A wins a tie; it flips to the other source on every grant.
    always_comb begin
        grant_a  = ne_a && (!ne_b || prio_a_q);
        grant_b  = ne_b && !grant_a;
        prio_a_d = prio_a_q;
        if (grant_a) begin
            prio_a_d = 1'b0;
        end else if (grant_b) begin
            prio_a_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_a_q <= 1'b1;
        end else begin
            prio_a_q <= prio_a_d;
        end
    end

    always_comb begin
        w_en            = grant_a || grant_b;
        rd_id_o         = '0;
        rd_write_data_o = '0;
        if (grant_a) begin
            rd_id_o         = head_rd_a;
            rd_write_data_o = head_data_a;
        end else if (grant_b) begin
            rd_id_o         = head_rd_b;
            rd_write_data_o = head_data_b;
        end
    end

    assign busy = ne_a || ne_b;

`ifdef WB_ARB_PERF_EN
    logic [15:0] stall_a_q, stall_b_q, conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_a_q  <= '0;
            stall_b_q  <= '0;
            conflict_q <= '0;
        end else begin
            if (a_valid && !a_ready && (stall_a_q != 16'hFFFF)) begin
                stall_a_q <= stall_a_q + 16'd1;
            end
            if (b_valid && !b_ready && (stall_b_q != 16'hFFFF)) begin
                stall_b_q <= stall_b_q + 16'd1;
            end
            if (ne_a && ne_b && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end

    assign stall_a_cnt  = stall_a_q;
    assign stall_b_cnt  = stall_b_q;
    assign conflict_cnt = conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter against a
//               queue-based reference model. Honours WB_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_rd, b_rd;
    logic [DATA_W-1:0] a_data, b_data;
    logic              w_en;
    logic [ADDR_W-1:0] rd_id_o;
    logic [DATA_W-1:0] rd_write_data_o;
    logic              busy;
`ifdef WB_ARB_PERF_EN
    logic [15:0]       stall_a_cnt, stall_b_cnt, conflict_cnt;
`endif

    regfile_wb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .a_rd            (a_rd),
        .a_data          (a_data),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_rd            (b_rd),
        .b_data          (b_data),
        .w_en            (w_en),
        .rd_id_o         (rd_id_o),
        .rd_write_data_o (rd_write_data_o),
`ifdef WB_ARB_PERF_EN
        .stall_a_cnt     (stall_a_cnt),
        .stall_b_cnt     (stall_b_cnt),
        .conflict_cnt    (conflict_cnt),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              qa[$];
    ent_t              qb[$];
    bit                m_next_a;
    int unsigned       m_stall_a, m_stall_b, m_conflict;
    logic [ADDR_W-1:0] wlog[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_next_a   = 1'b1;
        m_stall_a  = 0;
        m_stall_b  = 0;
        m_conflict = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One cycle: drive at the falling edge, check, advance the model across the rising edge.
    task automatic step(input bit av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input bit bv, input logic [ADDR_W-1:0] brd, input logic [DATA_W-1:0] bd,
                        output bit aacc, output bit bacc);
        bit                ea, eb, ga, gb;
        logic [ADDR_W-1:0] erd;
        logic [DATA_W-1:0] edat;
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        #1;
        ea   = qa.size() < DEPTH;
        eb   = qb.size() < DEPTH;
        ga   = (qa.size() > 0) && ((qb.size() == 0) || m_next_a);
        gb   = (qb.size() > 0) && !ga;
        erd  = ga ? qa[0].rd : (gb ? qb[0].rd : '0);
        edat = ga ? qa[0].d  : (gb ? qb[0].d  : '0);
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("w_en", w_en, ga || gb);
        chk("rd_id", rd_id_o, erd);
        chk("wdata", rd_write_data_o, edat);
        chk("busy", busy, (qa.size() > 0) || (qb.size() > 0));
`ifdef WB_ARB_PERF_EN
        chk("stall_a_cnt", stall_a_cnt, m_stall_a);
        chk("stall_b_cnt", stall_b_cnt, m_stall_b);
        chk("conflict_cnt", conflict_cnt, m_conflict);
`endif
        if (av && !ea && m_stall_a < 16'hFFFF) m_stall_a++;
        if (bv && !eb && m_stall_b < 16'hFFFF) m_stall_b++;
        if (qa.size() > 0 && qb.size() > 0 && m_conflict < 16'hFFFF) m_conflict++;
        if (w_en === 1'b1) wlog.push_back(rd_id_o);
        if (ga) begin void'(qa.pop_front()); m_next_a = 1'b0; end
        if (gb) begin void'(qb.pop_front()); m_next_a = 1'b1; end
        aacc = av && ea;
        bacc = bv && eb;
        if (aacc && ard != '0) qa.push_back('{rd: ard, d: ad});
        if (bacc && brd != '0) qb.push_back('{rd: brd, d: bd});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit x, y;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, x, y);
    endtask

    // Producers hold their request until accepted; rnd selects random valid/rd/data.
    task automatic traffic(input int n, input bit a_on, input bit b_on, input bit rnd);
        int                ka = 0, kb = 0;
        bit                av, bv, aacc, bacc;
        logic [ADDR_W-1:0] ard, brd;
        logic [DATA_W-1:0] ad, bd;
        av  = a_on && (!rnd || $urandom_range(0, 3) != 0);
        ard = rnd ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'(1 + ka);
        ad  = rnd ? $urandom : (32'hA000_0000 | ka);
        bv  = b_on && (!rnd || $urandom_range(0, 3) != 0);
        brd = rnd ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'(17 + kb);
        bd  = rnd ? $urandom : (32'hB000_0000 | kb);
        for (int i = 0; i < n; i++) begin
            step(av, ard, ad, bv, brd, bd, aacc, bacc);
            if (aacc || !av) begin
                if (aacc) ka++;
                av  = a_on && (!rnd || $urandom_range(0, 3) != 0);
                ard = rnd ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'(1 + ka);
                ad  = rnd ? $urandom : (32'hA000_0000 | ka);
            end
            if (bacc || !bv) begin
                if (bacc) kb++;
                bv  = b_on && (!rnd || $urandom_range(0, 3) != 0);
                brd = rnd ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'(17 + kb);
                bd  = rnd ? $urandom : (32'hB000_0000 | kb);
            end
        end
    endtask

    initial begin
        bit x, y;
        rst = 1'b1;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        idle(2);

        // Single A write, then drain
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, x, y);
        idle(3);

        // Write to x0 is accepted but never issued
        step(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, '0, x, y);
        chk("x0_accept", x, 1'b1);
        idle(3);

        // Both sources every cycle: strict alternation starting with A
        do_reset();
        wlog.delete();
        traffic(16, 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("alt_len", (wlog.size() >= 8), 1'b1);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk("alt_seq", wlog[i], (i % 2 == 0) ? (1 + i / 2) : (17 + i / 2));

        // A-only at full rate across pointer wrap
        do_reset();
        wlog.delete();
        traffic(8, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("aonly_len", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk("aonly_seq", wlog[i], i + 1);

        // Reset mid-drain discards pending entries
        do_reset();
        traffic(3, 1'b1, 1'b1, 1'b0);
        do_reset();
        wlog.delete();
        idle(3);
        chk("rst_drain_writes", wlog.size(), 0);

        // Randomized traffic
        do_reset();
        traffic(400, 1'b1, 1'b1, 1'b1);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
